// File: rtl/adder_word_sequencer.sv
// adder_word_sequencer
// Multi-word add controller that time-shares one external 16-bit adder.
// Operands of WORDS x 16 bits are fed to the adder one word per cycle,
// least-significant word first. The carry between words is chained
// through carry_q.
// Optional feature macro: SEQ_SUB_EN adds the op_sub port. With op_sub=1
// the block computes A-B by inverting B and forcing the initial carry to 1.
module adder_word_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   op_a,
  input  logic [16*WORDS-1:0]   op_b,
  input  logic                  op_cin,
`ifdef SEQ_SUB_EN
  input  logic                  op_sub,
`endif
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [16:0]           add_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [16*WORDS-1:0]   a_q, a_d;
  logic [16*WORDS-1:0]   b_q, b_d;
  logic [16*WORDS-1:0]   sum_q, sum_d;
  logic                  carry_q, carry_d;
`ifdef SEQ_SUB_EN
  logic                  sub_q, sub_d;
`endif

  // Bit offset of the word currently being processed.
  logic [IDX_W+3:0]      word_ofs_s;
  assign word_ofs_s = {idx_q, 4'h0};

  // Next-state logic: capture, per-word accumulate, and result hand-off.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = '0;
`ifdef SEQ_SUB_EN
          sub_d   = op_sub;
          // Two's-complement subtract needs +1 on the inverted B.
          carry_d = op_sub ? 1'b1 : op_cin;
`else
          carry_d = op_cin;
`endif
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[word_ofs_s +: 16] = add_sum[15:0];
        carry_d                 = add_sum[16];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // Returning to IDLE first keeps capture out of the hand-off cycle.
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Adder drive: selected word from registers during RUN, zero otherwise.
  always_comb begin
    add_a   = 16'h0000;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    if (state_q == ST_RUN) begin
      add_a   = a_q[word_ofs_s +: 16];
`ifdef SEQ_SUB_EN
      add_b   = sub_q ? ~b_q[word_ofs_s +: 16] : b_q[word_ofs_s +: 16];
`else
      add_b   = b_q[word_ofs_s +: 16];
`endif
      add_cin = carry_q;
    end else begin
      add_a   = 16'h0000;
      add_b   = 16'h0000;
      add_cin = 1'b0;
    end
  end

  // Handshake and status outputs decode registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Self-checking bench for adder_word_sequencer (WORDS=4).
// The bench provides the external 16-bit adder and a scoreboard of
// expected wide results. Define SEQ_SUB_EN to also cover subtraction.
module tb_adder_word_sequencer;

  localparam int W  = 4;
  localparam int DW = 16 * W;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          cout;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic          op_cin = 1'b0;
  logic          op_sub = 1'b0;
  logic [15:0]   add_a, add_b;
  logic          add_cin;
  logic [16:0]   add_sum;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_sum;
  logic          out_cout;
  logic          busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // External shared adder.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

  adder_word_sequencer #(.WORDS(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
`ifdef SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic cin, input logic sub);
    logic [DW:0] r;
    exp_t e;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
    else     r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    e.sum  = r[DW-1:0];
    e.cout = r[DW];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation until accepted; returns #1 after the accept edge.
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic cin, input logic sub, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    op_sub   = sub;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (ok) sb.push_back(model(a, b, cin, sub));
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 30 && !out_valid; i++) tick();
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
    n_checks++;
    if (out_sum !== '0 || out_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sum: out_sum=%h cout=%b, required 0 0", out_sum, out_cout);
    end
    n_checks++;
    if (add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_add: a=%h b=%h cin=%b, required 0 0 0", add_a, add_b, add_cin);
    end
    #3 rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_carry_chain();
    bit   ok;
    exp_t e;
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, ok);
    // Now just after accept edge T: out_valid must rise only after T+4.
    for (int k = 1; k <= W; k++) begin
      tick();
      n_checks++;
      if (out_valid !== (k == W)) begin
        n_fail++;
        $display("FAIL carry_latency: after T+%0d out_valid=%b, required %b",
                 k, out_valid, (k == W));
      end
    end
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum || out_cout !== e.cout || out_sum !== 64'h0000_0000_0001_0000) begin
      n_fail++;
      $display("FAIL carry_chain: sum=%h cout=%b, required %h %b", out_sum, out_cout, e.sum, e.cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_all_ones();
    bit   ok;
    exp_t e;
    issue({DW{1'b1}}, '0, 1'b1, 1'b0, ok);
    n_checks++;
    if (add_a !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL ones_add_a: add_a=%h, required ffff", add_a);
    end
    for (int k = 0; k < W; k++) begin
      n_checks++;
      if (add_cin !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ones_cin: run cycle %0d add_cin=%b busy=%b, required 1 1", k, add_cin, busy);
      end
      tick();
    end
    wait_valid(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || out_sum !== e.sum || out_cout !== e.cout || out_sum !== '0 || out_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_sum: valid=%b sum=%h cout=%b, required 1 %h %b", ok, out_sum, out_cout, e.sum, e.cout);
    end
    n_checks++;
    if (add_cin !== 1'b0 || add_a !== 16'h0) begin
      n_fail++;
      $display("FAIL ones_idle_add: add_a=%h add_cin=%b in DONE, required 0 0", add_a, add_cin);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, ok);
    wait_valid(ok);
    e = sb.pop_front();
    in_valid = 1'b1;
    op_a     = 64'h1;
    op_b     = 64'h1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e.sum || out_cout !== e.cout) begin
        n_fail++;
        $display("FAIL backpressure: cyc %0d valid=%b ready=%b sum=%h cout=%b, required 1 0 %h %b",
                 k, out_valid, in_ready, out_sum, out_cout, e.sum, e.cout);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_abort();
    bit   ok;
    bit   seen;
    exp_t e;
    issue(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1, 1'b0, ok);
    tick();                 // second RUN cycle in progress
    rst_n = 1'b0;
    sb.delete();            // aborted operation produces nothing
    #2;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || add_a !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b valid=%b ready=%b sum=%h add_a=%h, required 0 0 1 0 0",
               busy, out_valid, in_ready, out_sum, add_a);
    end
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_valid: out_valid seen=1, required 0");
    end
    issue(64'd61560, 64'd60101, 1'b0, 1'b0, ok);
    wait_valid(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || out_sum !== e.sum || out_sum !== 64'h0000_0000_0001_DB3D || out_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next: valid=%b sum=%h cout=%b, required 1 %h 0", ok, out_sum, out_cout, e.sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit            ok;
    exp_t          e;
    logic [DW-1:0] a, b;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if (n == 0) b = ~a;   // full carry propagate
      issue(a, b, 1'($urandom_range(0, 1)), 1'b0, ok);
      wait_valid(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || out_sum !== e.sum || out_cout !== e.cout) begin
        n_fail++;
        $display("FAIL b2b_%0d: valid=%b sum=%h cout=%b, required 1 %h %b", n, ok, out_sum, out_cout, e.sum, e.cout);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

`ifdef SEQ_SUB_EN
  task automatic test_sub();
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    issue(64'd5, 64'd8, 1'b0, 1'b1, ok);
    wait_valid(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || out_sum !== e.sum || out_sum !== 64'hFFFF_FFFF_FFFF_FFFD || out_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: sum=%h cout=%b, required fffffffffffffffd 0", out_sum, out_cout);
    end
    tick();
    issue(64'd8, 64'd5, 1'b0, 1'b1, ok);
    wait_valid(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || out_sum !== e.sum || out_sum !== 64'd3 || out_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_noborrow: sum=%h cout=%b, required 3 1", out_sum, out_cout);
    end
    tick();
    out_ready = 1'b0;
    op_sub    = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_all_ones();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
`ifdef SEQ_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
